// File: rtl/magnitude_pkg.sv
// Shared types and sizing helpers for the streaming magnitude pipeline.
package magnitude_pkg;

  typedef enum logic {RND_FLOOR, RND_NEAREST} round_mode_e;

  function automatic int magnitude_latency(int input_bits);
    return input_bits + 4;
  endfunction

  function automatic int root_bits(int sum_bits);
    return sum_bits / 2;
  endfunction

  function automatic int rem_bits(int sum_bits);
    return sum_bits / 2 + 2;
  endfunction

endpackage

// File: rtl/sqrt_stage.sv
// One restoring square-root iteration: retires one root bit per clock.
module sqrt_stage
  import magnitude_pkg::*;
#(
  parameter int SUM_BITS  = 32,
  parameter int STAGE_IDX = 0,
  parameter int TAG_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adv,
  input  logic                          in_valid,
  input  logic [SUM_BITS-1:0]           in_sum,
  input  logic [root_bits(SUM_BITS)-1:0] in_root,
  input  logic [rem_bits(SUM_BITS)-1:0] in_rem,
  input  logic [TAG_BITS-1:0]           in_tag,
  output logic                          out_valid,
  output logic [SUM_BITS-1:0]           out_sum,
  output logic [root_bits(SUM_BITS)-1:0] out_root,
  output logic [rem_bits(SUM_BITS)-1:0] out_rem,
  output logic [TAG_BITS-1:0]           out_tag
);

  localparam int RB = root_bits(SUM_BITS);
  localparam int MB = rem_bits(SUM_BITS);
  localparam int WB = MB + 2;

  logic [WB-1:0] shifted;
  logic [WB-1:0] trial;
  logic [WB-1:0] diff;
  logic          take;

  // Bring down the next radicand pair; try 4r+1 against it.
  always_comb begin
    shifted = {in_rem, in_sum[2*STAGE_IDX+1 -: 2]};
    trial   = WB'({in_root, 2'b01});
    diff    = shifted - trial;
    take    = shifted >= trial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      out_sum  <= in_sum;
      out_tag  <= in_tag;
      out_root <= (in_root << 1) | RB'(take);
      out_rem  <= take ? MB'(diff) : MB'(shifted);
    end
  end

endmodule

// File: rtl/magnitude_nr.sv
// Streaming exact |z| = sqrt(I^2 + Q^2) with tag sideband and backpressure.
module magnitude_nr
  import magnitude_pkg::*;
#(
  parameter int INPUT_BITS = 16,
  parameter int TAG_BITS   = 4,
  parameter int ROUND_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_BITS-1:0] in_i,
  input  logic [INPUT_BITS-1:0] in_q,
  input  logic [TAG_BITS-1:0]   in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_BITS-1:0] out_mag,
  output logic [TAG_BITS-1:0]   out_tag
);

  localparam int N  = INPUT_BITS;
  localparam int SB = 2 * N;
  localparam int MB = rem_bits(SB);

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic            va, vb, vc;
  logic [N-1:0]    abs_i, abs_q, abs_i_nx, abs_q_nx;
  logic [SB-1:0]   prod_i, prod_q;
  logic [SB-2:0]   sq_i, sq_q;
  logic [SB-1:0]   sum_c;
  logic [TAG_BITS-1:0] tag_a, tag_b, tag_c;

  // Most negative input maps to 2^(N-1), which fits unsigned N bits.
  always_comb begin
    abs_i_nx = in_i[N-1] ? (~in_i + N'(1)) : in_i;
    abs_q_nx = in_q[N-1] ? (~in_q + N'(1)) : in_q;
    prod_i   = {{N{1'b0}}, abs_i} * {{N{1'b0}}, abs_i};
    prod_q   = {{N{1'b0}}, abs_q} * {{N{1'b0}}, abs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va <= 1'b0;
      vb <= 1'b0;
      vc <= 1'b0;
    end else if (adv) begin
      va <= in_valid;
      vb <= va;
      vc <= vb;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      abs_i <= abs_i_nx;
      abs_q <= abs_q_nx;
      tag_a <= in_tag;
      sq_i  <= (SB-1)'(prod_i);
      sq_q  <= (SB-1)'(prod_q);
      tag_b <= tag_a;
      sum_c <= {1'b0, sq_i} + {1'b0, sq_q};
      tag_c <= tag_b;
    end
  end

  logic                v_r   [0:N];
  logic [SB-1:0]       sum_r [0:N-1];
  logic [N-1:0]        root_r[0:N];
  logic [MB-1:0]       rem_r [0:N];
  logic [TAG_BITS-1:0] tag_r [0:N];

  assign v_r[0]    = vc;
  assign sum_r[0]  = sum_c;
  assign root_r[0] = '0;
  assign rem_r[0]  = '0;
  assign tag_r[0]  = tag_c;

  for (genvar k = 0; k < N; k++) begin : g_root
    if (k < N - 1) begin : g_mid
      sqrt_stage #(
        .SUM_BITS (SB),
        .STAGE_IDX(N - 1 - k),
        .TAG_BITS (TAG_BITS)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .in_valid (v_r[k]),
        .in_sum   (sum_r[k]),
        .in_root  (root_r[k]),
        .in_rem   (rem_r[k]),
        .in_tag   (tag_r[k]),
        .out_valid(v_r[k+1]),
        .out_sum  (sum_r[k+1]),
        .out_root (root_r[k+1]),
        .out_rem  (rem_r[k+1]),
        .out_tag  (tag_r[k+1])
      );
    end else begin : g_last
      sqrt_stage #(
        .SUM_BITS (SB),
        .STAGE_IDX(N - 1 - k),
        .TAG_BITS (TAG_BITS)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .in_valid (v_r[k]),
        .in_sum   (sum_r[k]),
        .in_root  (root_r[k]),
        .in_rem   (rem_r[k]),
        .in_tag   (tag_r[k]),
        .out_valid(v_r[k+1]),
        .out_sum  (),
        .out_root (root_r[k+1]),
        .out_rem  (rem_r[k+1]),
        .out_tag  (tag_r[k+1])
      );
    end
  end

  logic         rnd;
  logic [N-1:0] mag_nx;

  // rem > r is exactly sqrt(S) >= r + 1/2 for integer S.
  always_comb begin
    rnd    = (ROUND_MODE == int'(RND_NEAREST)) && (MB'(root_r[N]) < rem_r[N]);
    mag_nx = root_r[N] + N'(rnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v_r[N];
      out_mag   <= mag_nx;
      out_tag   <= tag_r[N];
    end
  end

endmodule

// File: tb/tb_magnitude_nr.sv
// Self-checking bench: floor and nearest instances against a sqrt reference.
module tb_magnitude_nr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_i, in_q;
  logic [3:0]  in_tag;
  logic        in_ready_f, in_ready_n;
  logic        out_valid_f, out_valid_n;
  logic [15:0] mag_f, mag_n;
  logic [3:0]  tag_f, tag_n;

  always #5 clk = ~clk;

  magnitude_nr #(.INPUT_BITS(16), .TAG_BITS(4), .ROUND_MODE(0)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_f),
    .in_i(in_i), .in_q(in_q), .in_tag(in_tag),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .out_mag(mag_f), .out_tag(tag_f)
  );

  magnitude_nr #(.INPUT_BITS(16), .TAG_BITS(4), .ROUND_MODE(1)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_i(in_i), .in_q(in_q), .in_tag(in_tag),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_mag(mag_n), .out_tag(tag_n)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_chk = 0;
  bit stall_on = 0;
  logic [15:0] hold_mag;
  logic [3:0]  hold_tag;

  logic [15:0] qi[$];
  logic [15:0] qq[$];
  logic [3:0]  qt[$];
  int          qc[$];

  logic [15:0] ri, rq;
  logic [3:0]  rt;
  bit          acc;
  int          sent;

  function automatic longint isqrt(longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic longint ref_mag(logic [15:0] i, logic [15:0] q, bit nearest);
    longint a, b, s, r;
    a = longint'($signed(i));
    b = longint'($signed(q));
    s = a * a + b * b;
    r = isqrt(s);
    if (nearest && 4 * s > (2 * r + 1) * (2 * r + 1)) r++;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] i, input logic [15:0] q,
                      input logic [3:0] t, input bit rdy, output bit a);
    logic [15:0] ei, eq;
    logic [3:0]  et;
    int          ec;
    @(negedge clk);
    in_valid  = v;
    in_i      = i;
    in_q      = q;
    in_tag    = t;
    out_ready = rdy;
    #1;
    a = v && in_ready_f;
    if (a) begin
      qi.push_back(i);
      qq.push_back(q);
      qt.push_back(t);
      qc.push_back(cyc);
    end
    if (out_valid_f && out_ready) begin
      n_cmp++;
      assert (qi.size() != 0) else begin
        n_bad++;
        $error("FAIL stale_output: got mag %0d tag %0d, expected no output", mag_f, tag_f);
      end
      if (qi.size() != 0) begin
        ei = qi.pop_front();
        eq = qq.pop_front();
        et = qt.pop_front();
        ec = qc.pop_front();
        check("mag_floor", mag_f, ref_mag(ei, eq, 1'b0));
        check("mag_nearest", mag_n, ref_mag(ei, eq, 1'b1));
        check("tag_floor", tag_f, et);
        check("tag_nearest", tag_n, et);
        if (lat_chk) check("latency", cyc - ec, 20);
      end
    end
    if (!rdy && out_valid_f) begin
      check("in_ready_stall", in_ready_f, 0);
      if (stall_on) begin
        check("stall_mag", mag_f, hold_mag);
        check("stall_tag", tag_f, hold_tag);
      end
      hold_mag = mag_f;
      hold_tag = tag_f;
      stall_on = 1;
    end else begin
      stall_on = 0;
    end
    cyc++;
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 200 && qi.size() != 0; k++) step(0, '0, '0, '0, 1, a);
    check("drain_left", qi.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_i = '0;
    in_q = '0;
    in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid_f, 0);
    check("rst_out_mag", mag_n, 0);
    check("rst_out_tag", tag_f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready_f, 1);

    lat_chk = 1;
    step(1, 16'd3, 16'd4, 4'd5, 1, acc);
    drain();
    lat_chk = 0;

    step(1, 16'h8000, 16'h8000, 4'd1, 1, acc);
    step(1, 16'd2, 16'd3, 4'd2, 1, acc);
    step(1, 16'd1, 16'd1, 4'd3, 1, acc);
    step(1, 16'd0, 16'd0, 4'd4, 1, acc);
    step(1, 16'h7fff, 16'h8000, 4'd6, 1, acc);
    drain();

    sent = 0;
    for (int c = 0; c < 200 && sent < 30; c++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      rt = 4'($urandom);
      step(1, ri, rq, rt, !(c >= 25 && c < 30), acc);
      if (acc) sent++;
    end
    check("stream_sent", sent, 30);
    drain();

    for (int k = 0; k < 10; k++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      rt = 4'($urandom);
      step(1, ri, rq, rt, 0, acc);
    end
    repeat (15) step(0, '0, '0, '0, 0, acc);
    check("fill_out_valid", out_valid_f, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_f, 0);
    check("midrst_out_mag", mag_f, 0);
    check("midrst_out_tag", tag_n, 0);
    qi.delete();
    qq.delete();
    qt.delete();
    qc.delete();
    stall_on = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step(0, '0, '0, '0, 1, acc);
    step(1, 16'd7, 16'hffe8, 4'd9, 1, acc);
    drain();

    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      rt = 4'($urandom);
      if ($urandom_range(15) == 0) ri = 16'h8000;
      if ($urandom_range(15) == 0) rq = 16'h8000;
      step($urandom_range(3) != 0, ri, rq, rt, $urandom_range(1) == 1, acc);
      if (acc) sent++;
    end
    check("random_sent", sent, 10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
